// File: rtl/spi_crypto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_crypto_pkg
// Description : Shared definitions for the SPI crypto master: FSM state
//               encoding, chip-select idle value and phase-length helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_crypto_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_TURN = 3'd2,
        ST_RX   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Both slaves deselected.
    localparam logic [1:0] CS_IDLE = 2'b11;

    function automatic int msg_width(input int nb);
        return 32 * nb;
    endfunction

    function automatic int key_width(input int nk);
        return 32 * nk;
    endfunction

    // Cycles spent shifting the message and key out.
    function automatic int tx_len(input int nb, input int nk, input int lanes);
        return (msg_width(nb) + key_width(nk)) / lanes;
    endfunction

    // Cycles spent shifting the result block in.
    function automatic int rx_len(input int nb, input int lanes);
        return msg_width(nb) / lanes;
    endfunction

    // One counter serves every phase, so it is sized for the longest one.
    function automatic int cnt_width(input int nb, input int nk,
                                     input int lanes, input int turn);
        int longest;
        longest = tx_len(nb, nk, lanes);
        if (rx_len(nb, lanes) > longest) longest = rx_len(nb, lanes);
        if (turn > longest) longest = turn;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_crypto_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_crypto_master_if
// Description : Request/serial bus bundle of the SPI crypto master.
//   start, mode, abort, msg_in, key_in : transfer request (host -> master)
//   miso                               : serial data from slave
//   sclk, cs_n, mosi, mosi_oe          : serial bus towards slaves
//   busy, done, result                 : status and received block
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_crypto_master_if
    import spi_crypto_pkg::*;
#(
    parameter int NB    = 4,
    parameter int NK    = 8,
    parameter int LANES = 1
);
    localparam int MSG_W = msg_width(NB);
    localparam int KEY_W = key_width(NK);

    logic             start;
    logic             mode;
    logic             abort;
    logic [MSG_W-1:0] msg_in;
    logic [KEY_W-1:0] key_in;
    logic [LANES-1:0] miso;
    logic             sclk;
    logic [1:0]       cs_n;
    logic [LANES-1:0] mosi;
    logic             mosi_oe;
    logic             busy;
    logic             done;
    logic [MSG_W-1:0] result;

    modport master (
        input  start, mode, abort, msg_in, key_in, miso,
        output sclk, cs_n, mosi, mosi_oe, busy, done, result
    );

    modport slave (
        output start, mode, abort, msg_in, key_in, miso,
        input  sclk, cs_n, mosi, mosi_oe, busy, done, result
    );

endinterface
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_reg
// Description : Parallel-load shift register moving LANES bits per cycle
//               towards the MSB end.
//   in_clk, rst : clock, asynchronous active-low reset
//   load        : load load_data (has priority over shift)
//   shift       : shift left by LANES, shift_in entering at the LSB side
//   shift_out   : top LANES bits of the current contents
//   data_next   : contents after a shift this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_reg #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  wire              in_clk,
    input  wire              rst,
    input  wire              load,
    input  wire  [WIDTH-1:0] load_data,
    input  wire              shift,
    input  wire  [LANES-1:0] shift_in,
    output logic [LANES-1:0] shift_out,
    output logic [WIDTH-1:0] data_next
);
    logic [WIDTH-1:0] data;

    assign shift_out = data[WIDTH-1 -: LANES];
    assign data_next = {data[WIDTH-LANES-1:0], shift_in};

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= data_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_crypto_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_crypto_master
// Description : SPI master that ships {message, key} to an encrypt or
//               decrypt slave, waits a turnaround, then reads back one block.
//   in_clk : system clock (also forwarded as sclk)
//   rst    : asynchronous active-low reset
//   bus    : spi_crypto_master_if master modport (request, serial, status)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_crypto_master
    import spi_crypto_pkg::*;
#(
    parameter int NB    = 4,
    parameter int NK    = 8,
    parameter int LANES = 1,
    parameter int TURN  = 1
) (
    input wire in_clk,
    input wire rst,
    spi_crypto_master_if.master bus
);
    localparam int MSG_W  = msg_width(NB);
    localparam int KEY_W  = key_width(NK);
    localparam int TX_LEN = tx_len(NB, NK, LANES);
    localparam int RX_LEN = rx_len(NB, LANES);
    localparam int CNT_W  = cnt_width(NB, NK, LANES, TURN);

    localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_LEN - 1);
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_LEN - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN > 0) ? TURN - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       cs_sel;
    logic             drive;
    logic             done_pulse;
    logic [MSG_W-1:0] result_hold;

    logic                   capture;
    logic                   in_flight;
    logic [LANES-1:0]       tx_msb;
    logic [MSG_W+KEY_W-1:0] tx_next_unused;
    logic [LANES-1:0]       rx_msb_unused;
    logic [MSG_W-1:0]       rx_next;

    assign capture   = (state == ST_IDLE) && bus.start;
    assign in_flight = (state == ST_TX) || (state == ST_TURN) || (state == ST_RX);

    spi_shift_reg #(
        .WIDTH (MSG_W + KEY_W),
        .LANES (LANES)
    ) u_tx_shift (
        .in_clk    (in_clk),
        .rst       (rst),
        .load      (capture),
        .load_data ({bus.msg_in, bus.key_in}),
        .shift     (state == ST_TX),
        .shift_in  ({LANES{1'b0}}),
        .shift_out (tx_msb),
        .data_next (tx_next_unused)
    );

    spi_shift_reg #(
        .WIDTH (MSG_W),
        .LANES (LANES)
    ) u_rx_shift (
        .in_clk    (in_clk),
        .rst       (rst),
        .load      (capture),
        .load_data ({MSG_W{1'b0}}),
        .shift     (state == ST_RX),
        .shift_in  (bus.miso),
        .shift_out (rx_msb_unused),
        .data_next (rx_next)
    );

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            cs_sel      <= CS_IDLE;
            drive       <= 1'b0;
            done_pulse  <= 1'b0;
            result_hold <= '0;
        end else begin
            done_pulse <= 1'b0;
            if (in_flight && bus.abort) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                cs_sel  <= CS_IDLE;
                drive   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state   <= ST_TX;
                            bit_cnt <= '0;
                            // Only the selected slave goes low; the other stays deselected.
                            cs_sel  <= bus.mode ? 2'b01 : 2'b10;
                            drive   <= 1'b1;
                        end
                    end
                    ST_TX: begin
                        if (bit_cnt == TX_LAST) begin
                            bit_cnt <= '0;
                            drive   <= 1'b0;
                            if (TURN > 0) state <= ST_TURN;
                            else          state <= ST_RX;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_TURN: begin
                        if (bit_cnt == TURN_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_RX;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_RX: begin
                        if (bit_cnt == RX_LAST) begin
                            bit_cnt     <= '0;
                            state       <= ST_DONE;
                            cs_sel      <= CS_IDLE;
                            done_pulse  <= 1'b1;
                            // Take the shifted value so the final miso beat lands in result.
                            result_hold <= rx_next;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                        cs_sel  <= CS_IDLE;
                        drive   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sclk    = in_clk;
    assign bus.cs_n    = cs_sel;
    assign bus.mosi_oe = drive;
    assign bus.mosi    = drive ? tx_msb : {LANES{1'b0}};
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = done_pulse;
    assign bus.result  = result_hold;

endmodule
`default_nettype wire
